spark_pwm_multi: RTL and testbench

//   Multi-channel SparkMax servo-style PWM generator; next generation of the single-channel Spark PWM.
//   One shared frame counter drives NUM_CH independent outputs (pulse 1000-2000us, neutral ~1500us).

---
 rtl/spark_pwm_multi.sv | 135 +++++++++++++
 tb/tb_spark_pwm_multi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spark_pwm_multi.sv
// Multi-channel SparkMax servo PWM: one shared frame counter, per-channel slew limiting,
// update/ack handshake and a command watchdog that falls back to neutral.
module spark_pwm_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned PERIOD      = 4096,
    parameter int unsigned NEUTRAL     = 635,
    parameter int unsigned RAMP_STEP   = 0,
    parameter int unsigned WDOG_FRAMES = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     pwm_enable,
    input  logic [8*NUM_CH-1:0]   pwm_ratio,
    input  logic [NUM_CH-1:0]     pwm_direction,
    input  logic [NUM_CH-1:0]     pwm_update,
    output logic [NUM_CH-1:0]     pwm_done,
    output logic [NUM_CH-1:0]     pwm_signal,
    output logic                  frame_start,
    output logic [NUM_CH-1:0]     wdog_fault
);

    localparam int unsigned WD_W = (WDOG_FRAMES < 2) ? 1 : $clog2(WDOG_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_NEUTRAL = CNT_W'(NEUTRAL);
    localparam logic [CNT_W-1:0] CNT_STEP    = CNT_W'(RAMP_STEP);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PERIOD - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT    = WD_W'(WDOG_FRAMES);

    // Full-scale reverse/forward commands must stay inside one frame.
    if (NEUTRAL < 255 || NEUTRAL + 255 >= PERIOD || 64'(PERIOD) > (64'd1 << CNT_W)) begin : g_param_check
        $error("spark_pwm_multi: need 255 <= NEUTRAL, NEUTRAL+255 < PERIOD <= 2**CNT_W");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frame_q, frame_d;
    logic              boundary_c;
    logic [NUM_CH-1:0] active_q, active_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] fault_q, fault_d;
    logic [CNT_W-1:0]  cur_q   [NUM_CH];
    logic [CNT_W-1:0]  cur_d   [NUM_CH];
    logic [CNT_W-1:0]  req_q   [NUM_CH];
    logic [CNT_W-1:0]  req_d   [NUM_CH];
    logic [CNT_W-1:0]  req_val [NUM_CH];
    logic [WD_W-1:0]   wd_q    [NUM_CH];
    logic [WD_W-1:0]   wd_d    [NUM_CH];

    // One slew step of cur toward tgt, bounded by RAMP_STEP (0 = jump).
    function automatic logic [CNT_W-1:0] slew_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] res;
        res = tgt;
        if (RAMP_STEP != 0) begin
            if (tgt > cur && (tgt - cur) > CNT_STEP) begin
                res = cur + CNT_STEP;
            end else if (cur > tgt && (cur - tgt) > CNT_STEP) begin
                res = cur - CNT_STEP;
            end
        end
        return res;
    endfunction

    assign boundary_c = (cnt_q == '0);

    always_comb begin
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        frame_d  = (cnt_d == '0);
        active_d = active_q;
        done_d   = '0;
        fault_d  = fault_q;
        pwm_d    = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            req_d[n]   = req_q[n];
            cur_d[n]   = cur_q[n];
            wd_d[n]    = wd_q[n];
            req_val[n] = pwm_direction[n] ? CNT_NEUTRAL - CNT_W'(pwm_ratio[8*n +: 8])
                                          : CNT_NEUTRAL + CNT_W'(pwm_ratio[8*n +: 8]);
            if (boundary_c) begin
                active_d[n] = pwm_enable[n];
                if (pwm_update[n]) begin
                    req_d[n]   = req_val[n];
                    done_d[n]  = 1'b1;
                    wd_d[n]    = '0;
                    fault_d[n] = 1'b0;
                end else if (pwm_enable[n] && WDOG_FRAMES != 0 && wd_q[n] != WD_LIMIT) begin
                    wd_d[n] = wd_q[n] + WD_W'(1);
                    if (wd_d[n] == WD_LIMIT) begin
                        req_d[n]   = CNT_NEUTRAL;
                        fault_d[n] = 1'b1;
                    end
                end
                // A channel coming out of disable always ramps from neutral.
                cur_d[n] = pwm_enable[n] ? slew_toward(active_q[n] ? cur_q[n] : CNT_NEUTRAL, req_d[n])
                                         : CNT_NEUTRAL;
            end
            pwm_d[n] = active_d[n] && (cnt_q < cur_d[n]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            frame_q  <= 1'b0;
            active_q <= '0;
            done_q   <= '0;
            pwm_q    <= '0;
            fault_q  <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cur_q[n] <= CNT_NEUTRAL;
                req_q[n] <= CNT_NEUTRAL;
                wd_q[n]  <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            active_q <= active_d;
            done_q   <= done_d;
            pwm_q    <= pwm_d;
            fault_q  <= fault_d;
            for (int n = 0; n < NUM_CH; n++) begin
                cur_q[n] <= cur_d[n];
                req_q[n] <= req_d[n];
                wd_q[n]  <= wd_d[n];
            end
        end
    end

    assign pwm_signal  = pwm_q;
    assign pwm_done    = done_q;
    assign frame_start = frame_q;
    assign wdog_fault  = fault_q;

endmodule

// File: tb/tb_spark_pwm_multi.sv
// Directed scoreboard bench: three instances (no slew, slew 16, watchdog 3) run in lock-step,
// high-time per frame counted and compared against expectations queued with each command.
module tb_spark_pwm_multi;

    localparam int unsigned PERIOD = 1024;
    localparam int unsigned NCH    = 4;

    logic clock;
    logic reset_n;

    logic [NCH-1:0]   en_a, dir_a, upd_a, done_a, pwm_a, fault_a;
    logic [NCH-1:0]   en_b, dir_b, upd_b, done_b, pwm_b, fault_b;
    logic [NCH-1:0]   en_c, dir_c, upd_c, done_c, pwm_c, fault_c;
    logic [8*NCH-1:0] ratio_a, ratio_b, ratio_c;
    logic             fs_a, fs_b, fs_c;

    spark_pwm_multi #(.NUM_CH(NCH), .CNT_W(12), .PERIOD(PERIOD), .NEUTRAL(635),
                      .RAMP_STEP(0), .WDOG_FRAMES(0)) u_a (
        .clock(clock), .reset_n(reset_n), .pwm_enable(en_a), .pwm_ratio(ratio_a),
        .pwm_direction(dir_a), .pwm_update(upd_a), .pwm_done(done_a),
        .pwm_signal(pwm_a), .frame_start(fs_a), .wdog_fault(fault_a));

    spark_pwm_multi #(.NUM_CH(NCH), .CNT_W(12), .PERIOD(PERIOD), .NEUTRAL(635),
                      .RAMP_STEP(16), .WDOG_FRAMES(0)) u_b (
        .clock(clock), .reset_n(reset_n), .pwm_enable(en_b), .pwm_ratio(ratio_b),
        .pwm_direction(dir_b), .pwm_update(upd_b), .pwm_done(done_b),
        .pwm_signal(pwm_b), .frame_start(fs_b), .wdog_fault(fault_b));

    spark_pwm_multi #(.NUM_CH(NCH), .CNT_W(12), .PERIOD(PERIOD), .NEUTRAL(635),
                      .RAMP_STEP(0), .WDOG_FRAMES(3)) u_c (
        .clock(clock), .reset_n(reset_n), .pwm_enable(en_c), .pwm_ratio(ratio_c),
        .pwm_direction(dir_c), .pwm_update(upd_c), .pwm_done(done_c),
        .pwm_signal(pwm_c), .frame_start(fs_c), .wdog_fault(fault_c));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int inst;
        int ch;
        int kind;
        int exp;
    } exp_t;

    exp_t           sb[$];
    int             highs [3][NCH];
    logic [NCH-1:0] done_obs  [3];
    logic [NCH-1:0] fault_obs [3];
    int             n_cmp    = 0;
    int             n_err    = 0;
    int             frame_no = 0;
    string          inst_nm [3] = '{"a_ramp0", "b_ramp16", "c_wdog3"};
    string          kind_nm [3] = '{"high_clocks", "done", "wdog_fault"};

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cmd(input int inst, input int ch, input int ratio, input logic dir);
        case (inst)
            0:       begin ratio_a[8*ch +: 8] = 8'(ratio); dir_a[ch] = dir; upd_a[ch] = 1'b1; end
            1:       begin ratio_b[8*ch +: 8] = 8'(ratio); dir_b[ch] = dir; upd_b[ch] = 1'b1; end
            default: begin ratio_c[8*ch +: 8] = 8'(ratio); dir_c[ch] = dir; upd_c[ch] = 1'b1; end
        endcase
    endtask

    task automatic expect_hi(input int inst, input int ch, input int hi, input int done);
        sb.push_back('{inst, ch, 0, hi});
        sb.push_back('{inst, ch, 1, done});
    endtask

    task automatic expect_flt(input int inst, input int ch, input int flt);
        sb.push_back('{inst, ch, 2, flt});
    endtask

    task automatic sync_frame(output int waited);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (fs_a !== 1'b1 && waited < 2 * PERIOD);
    endtask

    // Starts at the counter==0 cycle; the following edge is the frame boundary.
    task automatic run_frame(input logic [NCH-1:0] dis_b);
        exp_t e;
        int   obs;
        int   fs_cnt;
        frame_no++;
        fs_cnt = 0;
        for (int k = 0; k < 3; k++)
            for (int ch = 0; ch < NCH; ch++) highs[k][ch] = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clock);
            if (i == 0) begin
                done_obs[0]  = done_a;  done_obs[1]  = done_b;  done_obs[2]  = done_c;
                fault_obs[0] = fault_a; fault_obs[1] = fault_b; fault_obs[2] = fault_c;
                upd_a = '0; upd_b = '0; upd_c = '0;
            end
            if (i == PERIOD / 2) en_b = en_b & ~dis_b;
            for (int ch = 0; ch < NCH; ch++) begin
                highs[0][ch] += int'(pwm_a[ch]);
                highs[1][ch] += int'(pwm_b[ch]);
                highs[2][ch] += int'(pwm_c[ch]);
            end
            fs_cnt += int'(fs_a);
        end
        check($sformatf("f%0d frame_start_pulses", frame_no), fs_cnt, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = highs[e.inst][e.ch];
                1:       obs = int'(done_obs[e.inst][e.ch]);
                default: obs = int'(fault_obs[e.inst][e.ch]);
            endcase
            check($sformatf("f%0d %s ch%0d %s", frame_no, inst_nm[e.inst], e.ch, kind_nm[e.kind]),
                  obs, e.exp);
        end
    endtask

    initial begin
        int waited;
        reset_n = 1'b0;
        en_a = '0; dir_a = '0; upd_a = '0; ratio_a = '0;
        en_b = '0; dir_b = '0; upd_b = '0; ratio_b = '0;
        en_c = '0; dir_c = '0; upd_c = '0; ratio_c = '0;
        repeat (3) @(negedge clock);
        check("reset pwm_a", int'(pwm_a), 0);
        check("reset done_a", int'(done_a), 0);
        check("reset fault_c", int'(fault_c), 0);
        check("reset frame_start", int'(fs_a), 0);
        reset_n = 1'b1;
        sync_frame(waited);
        check("first frame_start after reset", waited, PERIOD);

        // F1: forward 100 on every instance
        en_a[0] = 1'b1; cmd(0, 0, 100, 1'b0); expect_hi(0, 0, 735, 1); expect_hi(0, 1, 0, 0);
        en_b[0] = 1'b1; cmd(1, 0, 100, 1'b0); expect_hi(1, 0, 651, 1);
        en_c[0] = 1'b1; cmd(2, 0, 100, 1'b0); expect_hi(2, 0, 735, 1); expect_flt(2, 0, 0);
        expect_flt(0, 0, 0);
        run_frame('0);
        // F2
        expect_hi(0, 0, 735, 0); expect_hi(1, 0, 667, 0); expect_hi(2, 0, 735, 0); expect_flt(2, 0, 0);
        run_frame('0);
        // F3: full reverse
        cmd(0, 0, 255, 1'b1); expect_hi(0, 0, 380, 1);
        expect_hi(1, 0, 683, 0); expect_hi(2, 0, 735, 0); expect_flt(2, 0, 0);
        run_frame('0);
        // F4: zero reverse; watchdog expires on c
        cmd(0, 0, 0, 1'b1); expect_hi(0, 0, 635, 1);
        expect_hi(1, 0, 699, 0); expect_hi(2, 0, 635, 0); expect_flt(2, 0, 1);
        run_frame('0);
        // F5: zero forward; fault sticks
        cmd(0, 0, 0, 1'b0); expect_hi(0, 0, 635, 1);
        expect_hi(1, 0, 715, 0); expect_hi(2, 0, 635, 0); expect_flt(2, 0, 1);
        run_frame('0);
        // F6: update clears fault on c
        cmd(0, 0, 100, 1'b0); expect_hi(0, 0, 735, 1);
        expect_hi(1, 0, 731, 0);
        cmd(2, 0, 50, 1'b0); expect_hi(2, 0, 685, 1); expect_flt(2, 0, 0);
        run_frame('0);
        // F7: ramp settles
        expect_hi(0, 0, 735, 0); expect_hi(1, 0, 735, 0); expect_hi(2, 0, 685, 0); expect_flt(2, 0, 0);
        run_frame('0);
        // F8: all channels of a together; b disabled mid-frame
        en_a = '1;
        for (int ch = 0; ch < NCH; ch++) begin
            cmd(0, ch, 85 * ch, 1'b0);
            expect_hi(0, ch, 635 + 85 * ch, 1);
        end
        expect_hi(1, 0, 735, 0); expect_hi(2, 0, 685, 0); expect_flt(2, 0, 0);
        run_frame(4'b0001);
        // F9: b disabled accepts update; c update on the expiry frame wins
        for (int ch = 0; ch < NCH; ch++) expect_hi(0, ch, 635 + 85 * ch, 0);
        cmd(1, 0, 100, 1'b0); expect_hi(1, 0, 0, 1);
        cmd(2, 0, 20, 1'b1); expect_hi(2, 0, 615, 1); expect_flt(2, 0, 0);
        run_frame('0);
        // F10: b re-enabled ramps from neutral
        en_b[0] = 1'b1;
        for (int ch = 0; ch < NCH; ch++) expect_hi(0, ch, 635 + 85 * ch, 0);
        expect_hi(1, 0, 651, 0); expect_hi(2, 0, 615, 0); expect_flt(2, 0, 0);
        run_frame('0);
        // F11
        for (int ch = 0; ch < NCH; ch++) expect_hi(0, ch, 635 + 85 * ch, 0);
        expect_hi(1, 0, 667, 0); expect_hi(2, 0, 615, 0); expect_flt(2, 0, 0);
        run_frame('0);

        // Reset in the middle of the high phase
        repeat (300) @(negedge clock);
        check("pre-reset pwm_a", int'(pwm_a), 15);
        check("pre-reset pwm_b", int'(pwm_b[0]), 1);
        reset_n = 1'b0;
        #1;
        check("async reset pwm_a", int'(pwm_a), 0);
        check("async reset pwm_b", int'(pwm_b), 0);
        check("async reset pwm_c", int'(pwm_c), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        sync_frame(waited);
        check("frame_start after mid-frame reset", waited, PERIOD);
        // F12: targets back at neutral, channels still enabled
        for (int ch = 0; ch < NCH; ch++) expect_hi(0, ch, 635, 0);
        expect_hi(1, 0, 635, 0); expect_hi(2, 0, 635, 0); expect_flt(2, 0, 0);
        run_frame('0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
